// File: rtl/dbg_halt_ctrl.sv
// ---------------------------------------------------------------------------
// dbg_halt_ctrl
//
// Debug halt / resume / single-step sequencer for the 3-stage RV32I core.
// Watches the MW stage for a clean retirement boundary, then freezes fetch,
// flushes the younger instructions and records dpc/cause. On resume it
// pulses a PC redirect to dpc and optionally arms a single step.
// dbg_stall and dbg_flush are ORed into the pipeline control next to the
// forwarding/stall unit.
//
// Optional feature: define EBREAK_HALT_EN to make an ebreak in MW enter
// debug halt directly (dpc = pc of the ebreak, cause = 1). When undefined,
// ebreak is not decoded here and takes the normal trap path.
//
// Parameters
//   TIMEOUT        max PEND cycles before a forced halt (1..255)
//
// Ports
//   i_clk          core clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_haltreq      halt request level, held until halted
//   i_resumereq    resume request, one-cycle pulse
//   i_step_en      dcsr.step, sampled together with i_resumereq
//   i_valid_3      MW holds a real instruction
//   i_hz_stall     hazard stall; MW does not retire while high
//   i_ir_3         instruction in MW
//   i_pc_3         PC of the MW instruction
//   i_pc_next      architectural next PC after the MW instruction
//   i_pc_f         current fetch PC
//   o_dbg_stall    freeze PC / fetch
//   o_dbg_flush    one-cycle IF/ID flush on halt entry
//   o_halted       core in debug halt (includes the resume cycle)
//   o_running      inverse of o_halted
//   o_resumeack    one-cycle pulse on resume
//   o_redirect     one-cycle pulse; datapath loads PC from o_redirect_pc
//   o_redirect_pc  equals dpc
//   o_dpc          debug PC register
//   o_cause        dcsr.cause: 1 ebreak, 3 haltreq, 4 step, 0 none
//
// States
//   RUN     | normal execution, no stall
//   PEND    | halt requested, pipeline runs until a boundary or timeout
//   HALTED  | core frozen in debug mode
//   RESUME  | one cycle: acknowledge resume and redirect PC to dpc
//   STEP    | run until the first boundary, then re-halt with cause 4
// ---------------------------------------------------------------------------
module dbg_halt_ctrl #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_haltreq,
    input  logic        i_resumereq,
    input  logic        i_step_en,
    input  logic        i_valid_3,
    input  logic        i_hz_stall,
    input  logic [31:0] i_ir_3,
    input  logic [31:0] i_pc_3,
    input  logic [31:0] i_pc_next,
    input  logic [31:0] i_pc_f,
    output logic        o_dbg_stall,
    output logic        o_dbg_flush,
    output logic        o_halted,
    output logic        o_running,
    output logic        o_resumeack,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_dpc,
    output logic [2:0]  o_cause
);

    localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [2:0]  CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0]  CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0]  CAUSE_STEP    = 3'd4;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_PEND   = 3'd1,
        ST_HALTED = 3'd2,
        ST_RESUME = 3'd3,
        ST_STEP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_dpc;
    logic [2:0]  r_cause;
    logic        r_step_armed;
    logic        r_stall;
    logic        r_halted;
    logic        r_resume;
    logic        r_flush;

    state_t      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [31:0] w_dpc_nxt;
    logic [2:0]  w_cause_nxt;
    logic        w_step_armed_nxt;
    logic        w_enter;
    logic        w_boundary;
    logic        w_ebreak;
    logic        w_live;

    assign w_boundary = i_valid_3 && !i_hz_stall;

`ifdef EBREAK_HALT_EN
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
    // hz_stall is deliberately ignored: the ebreak never retires anyway.
    assign w_ebreak = i_valid_3 && (i_ir_3 == EBREAK_INSN);
`else
    logic w_unused_ebreak_inputs;
    assign w_ebreak = 1'b0;
    assign w_unused_ebreak_inputs = ^{i_ir_3, i_pc_3};
`endif

    // States in which the pipeline runs and a halt may be entered.
    assign w_live = (r_state == ST_RUN) || (r_state == ST_PEND) || (r_state == ST_STEP);

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_dpc_nxt        = r_dpc;
        w_cause_nxt      = r_cause;
        w_step_armed_nxt = r_step_armed;
        w_enter          = 1'b0;

        if (w_live) begin
            if (w_ebreak) begin
`ifdef EBREAK_HALT_EN
                w_dpc_nxt = i_pc_3;
`endif
                w_cause_nxt = CAUSE_EBREAK;
                w_enter     = 1'b1;
            end else if (i_haltreq && w_boundary) begin
                w_dpc_nxt   = i_pc_next;
                w_cause_nxt = CAUSE_HALTREQ;
                w_enter     = 1'b1;
            end else if (i_haltreq && (r_state == ST_PEND) && (r_cnt == 8'd1)) begin
                // Terminal count: this PEND cycle takes the counter to zero.
                // No boundary is available, so resume from the fetch PC.
                w_dpc_nxt   = i_pc_f;
                w_cause_nxt = CAUSE_HALTREQ;
                w_enter     = 1'b1;
            end else if (i_haltreq && (r_state != ST_PEND)) begin
                w_state_nxt = ST_PEND;
                w_cnt_nxt   = TIMEOUT_CNT;
            end else if (i_haltreq) begin
                w_cnt_nxt = r_cnt - 8'd1;
            end else if ((r_state == ST_STEP) && w_boundary) begin
                w_dpc_nxt   = i_pc_next;
                w_cause_nxt = CAUSE_STEP;
                w_enter     = 1'b1;
            end else if (r_state == ST_PEND) begin
                w_state_nxt = ST_RUN;
            end

            if (w_enter) begin
                w_state_nxt = ST_HALTED;
                w_cnt_nxt   = 8'd0;
            end
        end else begin
            case (r_state)
                ST_HALTED: begin
                    // A resume while haltreq is still asserted is dropped.
                    if (i_resumereq && !i_haltreq) begin
                        w_state_nxt      = ST_RESUME;
                        w_step_armed_nxt = i_step_en;
                    end
                end
                ST_RESUME: begin
                    w_state_nxt      = r_step_armed ? ST_STEP : ST_RUN;
                    w_step_armed_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_RUN;
            r_cnt        <= 8'd0;
            r_dpc        <= 32'd0;
            r_cause      <= 3'd0;
            r_step_armed <= 1'b0;
            r_stall      <= 1'b0;
            r_halted     <= 1'b0;
            r_resume     <= 1'b0;
            r_flush      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_dpc        <= w_dpc_nxt;
            r_cause      <= w_cause_nxt;
            r_step_armed <= w_step_armed_nxt;
            // Outputs are registered from the next state so they line up
            // with the state they describe and never see an input path.
            r_stall      <= (w_state_nxt == ST_HALTED) || (w_state_nxt == ST_RESUME);
            r_halted     <= (w_state_nxt == ST_HALTED) || (w_state_nxt == ST_RESUME);
            r_resume     <= (w_state_nxt == ST_RESUME);
            r_flush      <= w_enter;
        end
    end

    assign o_dbg_stall   = r_stall;
    assign o_dbg_flush   = r_flush;
    assign o_halted      = r_halted;
    assign o_running     = !r_halted;
    assign o_resumeack   = r_resume;
    assign o_redirect    = r_resume;
    assign o_redirect_pc = r_dpc;
    assign o_dpc         = r_dpc;
    assign o_cause       = r_cause;

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
module tb_dbg_halt_ctrl;

    localparam int          TO     = 8;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef EBREAK_HALT_EN
    localparam bit EBK_EN = 1'b1;
`else
    localparam bit EBK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        haltreq = 1'b0, resumereq = 1'b0, step_en = 1'b0;
    logic        valid_3 = 1'b0, hz_stall = 1'b0;
    logic [31:0] ir_3 = NOP, pc_3 = 32'd0, pc_next = 32'd0, pc_f = 32'd0;

    logic        dbg_stall, dbg_flush, halted, running, resumeack, redirect;
    logic [31:0] redirect_pc, dpc;
    logic [2:0]  cause;

    dbg_halt_ctrl #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_haltreq(haltreq), .i_resumereq(resumereq),
        .i_step_en(step_en), .i_valid_3(valid_3), .i_hz_stall(hz_stall),
        .i_ir_3(ir_3), .i_pc_3(pc_3), .i_pc_next(pc_next), .i_pc_f(pc_f),
        .o_dbg_stall(dbg_stall), .o_dbg_flush(dbg_flush), .o_halted(halted),
        .o_running(running), .o_resumeack(resumeack), .o_redirect(redirect),
        .o_redirect_pc(redirect_pc), .o_dpc(dpc), .o_cause(cause)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Behavioural model: tracks what the debug module has asked for and what
    // the core must be doing, then derives the outputs from that.
    bit          m_halt, m_resume, m_step, m_pend, m_step_after, m_flush;
    int          m_wait;
    logic [31:0] m_dpc;
    logic [2:0]  m_cause;

    task automatic m_enter(input logic [31:0] pc, input logic [2:0] c);
        m_halt  = 1; m_pend = 0; m_step = 0; m_flush = 1;
        m_dpc   = pc; m_cause = c;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_halt = 0; m_resume = 0; m_step = 0; m_pend = 0; m_step_after = 0;
            m_flush = 0; m_wait = 0; m_dpc = 0; m_cause = 0;
        end else begin
            bit bnd, ebk;
            bnd = valid_3 && !hz_stall;
            ebk = EBK_EN && valid_3 && (ir_3 == EBREAK);
            m_flush = 0;
            if (m_halt) begin
                if (resumereq && !haltreq) begin
                    m_halt = 0; m_resume = 1; m_step_after = step_en;
                end
            end else if (m_resume) begin
                m_resume = 0; m_step = m_step_after;
            end else if (ebk)                               m_enter(pc_3, 3'd1);
            else if (haltreq && bnd)                        m_enter(pc_next, 3'd3);
            else if (haltreq && m_pend && m_wait == 1)      m_enter(pc_f, 3'd3);
            else if (haltreq && !m_pend) begin
                m_pend = 1; m_wait = TO; m_step = 0;
            end else if (haltreq)                           m_wait = m_wait - 1;
            else if (m_step && bnd)                         m_enter(pc_next, 3'd4);
            else                                            m_pend = 0;
        end
    end

    always @(negedge clk) begin
        logic in_dbg;
        in_dbg = m_halt || m_resume;
        check("outputs",
              {7'd0, halted, running, dbg_stall, dbg_flush, resumeack, redirect,
               redirect_pc, dpc, cause},
              {7'd0, in_dbg, !in_dbg, in_dbg, m_flush, m_resume, m_resume,
               m_dpc, m_dpc, m_cause});
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_resume(input bit s);
        haltreq = 0; resumereq = 1; step_en = s;
        cyc();
        resumereq = 0; step_en = 0;
        cyc();
    endtask

    initial begin
        #1 rst = 1;
        cyc(2);
        rst = 0;
        check("reset_running", running, 1);
        check("reset_halted", halted, 0);
        check("reset_dpc_cause", {dpc, cause}, 0);

        // Halt at a boundary on the first request cycle.
        haltreq = 1; valid_3 = 1; pc_3 = 32'h100; pc_next = 32'h104;
        cyc();
        valid_3 = 0;
        check("halt_entry", {halted, dbg_flush, dpc, cause}, {2'b11, 32'h104, 3'd3});
        cyc();
        check("flush_one_cycle", {halted, dbg_flush}, 2'b10);

        // resumereq while haltreq is still high is ignored.
        resumereq = 1;
        cyc();
        resumereq = 0;
        check("resume_ignored", {halted, resumeack}, 2'b10);
        cyc();

        // Resume into single step, then one boundary.
        haltreq = 0; resumereq = 1; step_en = 1;
        cyc();
        resumereq = 0; step_en = 0;
        check("resume_pulse", {resumeack, redirect, redirect_pc, running},
              {2'b11, 32'h104, 1'b0});
        cyc();
        check("step_running", running, 1);
        valid_3 = 1; pc_3 = 32'h104; pc_next = 32'h108;
        cyc();
        valid_3 = 0;
        check("step_halt", {halted, dpc, cause}, {1'b1, 32'h108, 3'd4});

        // Plain resume: boundaries afterwards do not halt.
        do_resume(0);
        valid_3 = 1;
        cyc(4);
        valid_3 = 0;
        check("run_no_halt", running, 1);

        // Forced halt after TIMEOUT edges without a boundary.
        haltreq = 1; pc_f = 32'h200;
        cyc();
        cyc(TO - 1);
        check("timeout_not_yet", halted, 0);
        cyc();
        check("timeout_halt", {halted, dpc, cause}, {1'b1, 32'h200, 3'd3});
        do_resume(0);

        // Dropping haltreq in PEND returns to RUN.
        haltreq = 1;
        cyc(3);
        haltreq = 0;
        cyc(12);
        check("drop_haltreq", {running, dbg_stall}, 2'b10);

        // hz_stall blocks the boundary until it drops.
        haltreq = 1; valid_3 = 1; hz_stall = 1; pc_next = 32'h304; pc_f = 32'h300;
        cyc(3);
        check("hz_stall_hold", halted, 0);
        hz_stall = 0;
        cyc();
        valid_3 = 0;
        check("hz_release", {halted, dpc}, {1'b1, 32'h304});
        do_resume(1);

        // Step interrupted by haltreq with no boundary goes through PEND.
        haltreq = 1;
        cyc();
        check("step_to_pend", running, 1);
        valid_3 = 1; pc_next = 32'h404;
        cyc();
        valid_3 = 0;
        check("step_pend_halt", {halted, dpc, cause}, {1'b1, 32'h404, 3'd3});
        do_resume(1);

        // haltreq and boundary together during a step: cause is haltreq.
        haltreq = 1; valid_3 = 1; pc_next = 32'h504;
        cyc();
        valid_3 = 0;
        check("step_haltreq", {halted, dpc, cause}, {1'b1, 32'h504, 3'd3});
        do_resume(0);

        // ebreak in MW.
        valid_3 = 1; ir_3 = EBREAK; pc_3 = 32'h80; pc_next = 32'h84;
        cyc();
        valid_3 = 0; ir_3 = NOP;
        if (EBK_EN) check("ebreak_halt", {halted, dpc, cause}, {1'b1, 32'h80, 3'd1});
        else        check("ebreak_ignored", running, 1);
        do_resume(0);

        // Reset in the middle of HALTED.
        haltreq = 1; valid_3 = 1; pc_next = 32'h604;
        cyc();
        haltreq = 0; valid_3 = 0;
        check("pre_reset_halted", halted, 1);
        rst = 1;
        #1;
        check("reset_mid_halted", {running, halted, dbg_stall, dbg_flush, resumeack, dpc, cause},
              {5'b10000, 32'd0, 3'd0});
        cyc(2);
        rst = 0;
        cyc();

        // Mixed traffic, checked against the model every cycle.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) haltreq = ~haltreq;
            resumereq = ($urandom_range(0, 5) == 0);
            step_en   = $urandom_range(0, 1);
            valid_3   = ($urandom_range(0, 3) != 0);
            hz_stall  = ($urandom_range(0, 2) == 0);
            ir_3      = ($urandom_range(0, 9) == 0) ? EBREAK : NOP;
            pc_3      = $urandom & 32'hFFFF_FFFC;
            pc_next   = $urandom & 32'hFFFF_FFFC;
            pc_f      = $urandom & 32'hFFFF_FFFC;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
